// File: rtl/alu_exec_stage.sv
// Registered ARM data-processing execute stage: ALU, condition check, NZCV flags.
// Optional macro ALU_SHIFT_CARRY_EN: flag-setting logical ops take C from the shifter carry-out.
module alu_exec_stage #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_in,
  input  logic               stall_in,
  input  logic [3:0]         cond_in,
  input  logic [3:0]         opcode_in,
  input  logic               s_bit_in,
  input  logic [DATA_W-1:0]  rn_in,
  input  logic [DATA_W-1:0]  src2_in,
  input  logic [RADDR_W-1:0] rd_addr_in,
`ifdef ALU_SHIFT_CARRY_EN
  input  logic               shifter_carry_in,
`endif
  output logic               valid_out,
  output logic [DATA_W-1:0]  result_out,
  output logic [RADDR_W-1:0] rd_addr_out,
  output logic               reg_write_out,
  output logic               cond_pass_out,
  output logic [3:0]         flags_out
);

  logic               valid_q, wr_q, pass_q;
  logic [DATA_W-1:0]  result_q;
  logic [RADDR_W-1:0] rd_q;
  logic [3:0]         flags_q, flags_d;

  logic n_f, z_f, c_f, v_f;
  assign {n_f, z_f, c_f, v_f} = flags_q;

  logic pass;
  always_comb begin
    pass = 1'b0;
    case (cond_in)
      4'h0: pass = z_f;
      4'h1: pass = ~z_f;
      4'h2: pass = c_f;
      4'h3: pass = ~c_f;
      4'h4: pass = n_f;
      4'h5: pass = ~n_f;
      4'h6: pass = v_f;
      4'h7: pass = ~v_f;
      4'h8: pass = c_f & ~z_f;
      4'h9: pass = ~c_f | z_f;
      4'hA: pass = (n_f == v_f);
      4'hB: pass = (n_f != v_f);
      4'hC: pass = ~z_f & (n_f == v_f);
      4'hD: pass = z_f | (n_f != v_f);
      4'hE: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

  // Every arithmetic op is x + y + cin; subtraction uses ~operand so C is NOT borrow.
  logic [DATA_W-1:0] add_x, add_y;
  logic              add_cin, is_arith;
  always_comb begin
    add_x    = rn_in;
    add_y    = src2_in;
    add_cin  = 1'b0;
    is_arith = 1'b1;
    case (opcode_in)
      4'h2, 4'hA: begin add_y = ~src2_in; add_cin = 1'b1; end
      4'h3:       begin add_x = src2_in; add_y = ~rn_in; add_cin = 1'b1; end
      4'h4, 4'hB: ;
      4'h5:       add_cin = c_f;
      4'h6:       begin add_y = ~src2_in; add_cin = c_f; end
      4'h7:       begin add_x = src2_in; add_y = ~rn_in; add_cin = c_f; end
      default:    is_arith = 1'b0;
    endcase
  end

  logic [DATA_W:0] sum;
  logic            add_v;
  assign sum   = {1'b0, add_x} + {1'b0, add_y} + {{DATA_W{1'b0}}, add_cin};
  assign add_v = (add_x[DATA_W-1] == add_y[DATA_W-1]) & (sum[DATA_W-1] != add_x[DATA_W-1]);

  logic [DATA_W-1:0] res;
  always_comb begin
    res = sum[DATA_W-1:0];
    case (opcode_in)
      4'h0, 4'h8: res = rn_in & src2_in;
      4'h1, 4'h9: res = rn_in ^ src2_in;
      4'hC:       res = rn_in | src2_in;
      4'hD:       res = src2_in;
      4'hE:       res = rn_in & ~src2_in;
      4'hF:       res = ~src2_in;
      default:    ;
    endcase
  end

  logic is_test, flag_we, logic_c;
  assign is_test = (opcode_in[3:2] == 2'b10);
  assign flag_we = valid_in & pass & (s_bit_in | is_test);
`ifdef ALU_SHIFT_CARRY_EN
  assign logic_c = shifter_carry_in;
`else
  assign logic_c = c_f;
`endif
  assign flags_d = {res[DATA_W-1], ~|res,
                    is_arith ? sum[DATA_W] : logic_c,
                    is_arith ? add_v       : v_f};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      wr_q     <= 1'b0;
      pass_q   <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
      flags_q  <= 4'b0000;
    end else if (!stall_in) begin
      valid_q <= valid_in;
      wr_q    <= valid_in & pass & ~is_test;
      pass_q  <= valid_in & pass;
      if (valid_in) begin
        result_q <= res;
        rd_q     <= rd_addr_in;
      end
      if (flag_we) flags_q <= flags_d;
    end
  end

  assign valid_out     = valid_q;
  assign result_out    = result_q;
  assign rd_addr_out   = rd_q;
  assign reg_write_out = wr_q;
  assign cond_pass_out = pass_q;
  assign flags_out     = flags_q;

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Registered execute stage directly downstream of the operand-2 barrel shifter.
- Consumes the shifted operand 2 and Rn, performs the 16 ARM data-processing operations and evaluates the instruction condition field.
- Holds the architectural NZCV flags register; presents the result, destination and write-enable to register-file writeback one cycle later.

Parameters:
- DATA_W, 32, operand/result width; must equal the shifter output width.
- RADDR_W, 4, destination register address width.

Ports:
- clk  in  1  clock; rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid_in  in  1  an instruction is presented this cycle.
- stall_in  in  1  freezes all stage state when high.
- cond_in  in  4  ARM condition field [31:28].
- opcode_in  in  4  data-processing opcode [24:21].
- s_bit_in  in  1  set-flags bit [20].
- rn_in  in  DATA_W  first operand.
- src2_in  in  DATA_W  shifted operand 2 from the shifter.
- rd_addr_in  in  RADDR_W  destination register.
- shifter_carry_in  in  1  shifter carry-out; present only with ALU_SHIFT_CARRY_EN.
- valid_out  out  1  registered valid.
- result_out  out  DATA_W  registered result.
- rd_addr_out  out  RADDR_W  registered destination.
- reg_write_out  out  1  writeback enable.
- cond_pass_out  out  1  registered condition-check result.
- flags_out  out  4  architectural {N,Z,C,V}.

Behaviour:
- Reset (async, rst_n=0): valid_out, reg_write_out, cond_pass_out = 0; result_out = 0; rd_addr_out = 0; flags_out = 4'b0000. Release is synchronous to the next clk edge.
- Latency: 1 cycle. Inputs captured at edge k appear on outputs after edge k; throughput 1 per cycle.
- stall_in=1: no register changes, flags included. Outputs hold. Input is not consumed. stall_in overrides valid_in.
- Condition check uses the committed flags_out at capture time.
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL (1110) always passes; 1111 never passes.
- Back-to-back: flags written at edge k are visible to the condition check of the instruction captured at edge k+1. No hazard bubble.
- Operations (A=rn_in, B=src2_in, Cin=flags C):
  - AND A&B; EOR A^B; SUB A-B; RSB B-A; ADD A+B; ADC A+B+Cin; SBC A-B-!Cin; RSC B-A-!Cin.
  - TST A&B; TEQ A^B; CMP A-B; CMN A+B.
  - ORR A|B; MOV B; BIC A&~B; MVN ~B.
- Arithmetic is done in DATA_W+1 bits.
  - C = bit DATA_W of the sum. Subtract is implemented as add-of-complement, so C = NOT borrow; 5-5 gives C=1.
  - V = signed overflow of the DATA_W-bit operation.
- Flag update enable = valid_in & pass & (s_bit_in | opcode in {TST,TEQ,CMP,CMN}).
  - N = result[DATA_W-1]; Z = (result==0).
  - Arithmetic ops write C and V.
  - Logical ops leave V unchanged. Logical-op C: see Optional Feature.
- reg_write_out (registered) = valid_in & pass & opcode not in {TST,TEQ,CMP,CMN}.
- cond_pass_out = pass when valid_in, else 0.
- valid_in=0 (no stall): valid_out, reg_write_out, cond_pass_out go 0. result_out and rd_addr_out hold their previous values. Flags unchanged.
- Failed condition: valid_out=1, reg_write_out=0, cond_pass_out=0. result_out still loads the computed value. Flags unchanged.
- Reset mid-stream: in-flight instruction discarded; flags return to 0.

Optional Feature:
- ALU_SHIFT_CARRY_EN defined:
  - shifter_carry_in port exists.
  - Flag-setting logical ops (AND, EOR, TST, TEQ, ORR, MOV, BIC, MVN) write C = shifter_carry_in.
- Undefined:
  - Port absent.
  - Logical ops leave C unchanged.
- Arithmetic behaviour is identical in both builds.

Test Plan:
- Reset: rst_n low mid-cycle with valid_in=1 -> all outputs 0 immediately, no clk edge required; flags_out=0000.
- CMP then BEQ-conditioned op: CMP rn=5,src2=5, cond AL -> flags 0110 (Z,C). Next cycle ADD cond EQ rn=1,src2=2 -> result_out=3, reg_write_out=1. Same ADD with cond NE -> reg_write_out=0, cond_pass_out=0.
- Overflow: ADDS rn=0x7FFFFFFF, src2=1 -> result 0x80000000, flags 1001. SUBS rn=0, src2=1 -> 0xFFFFFFFF, flags 1000.
- ADC chain: ADDS 0xFFFFFFFF+1 -> result 0, C=1. Then ADC rn=0, src2=0 -> result 1. Flags stay 0110 because S=0.
- Stall: hold stall_in=1 for 3 cycles while inputs change -> outputs and flags frozen. On release, the presented instruction is captured next edge.
- Logical carry: MOVS src2=0, shifter_carry_in=1, starting flags 0000 -> flags 0110 with ALU_SHIFT_CARRY_EN; 0100 without.
